// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline constants for decode-side hazard tracking.
// Holds the register index/count widths and the always-execute condition code.
package hazard_scoreboard_pkg;

    localparam int NUM_REGS  = 16;
    localparam int REG_IDX_W = 4;
    localparam int SB_CNT_W  = 2;

    localparam logic [3:0] COND_AL = 4'b1110;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_IDX_W-1:0] idx);
        logic [NUM_REGS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_counter.sv
// Per-register saturating pending-write counter.
// Latency: count updates on the next rising edge; ovf/unf flag the offending cycle.
// Backpressure: none; an increment at max or decrement at zero is dropped and reported.
module sb_counter
    import hazard_scoreboard_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic nonzero,
    output logic one,
    output logic ovf,
    output logic unf
);

    localparam logic [SB_CNT_W-1:0] CNT_MAX = {SB_CNT_W{1'b1}};
    localparam logic [SB_CNT_W-1:0] CNT_ONE = SB_CNT_W'(1);

    logic [SB_CNT_W-1:0] cnt_q;
    logic [SB_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf   = 1'b0;
        unf   = 1'b0;
        // Simultaneous inc and dec cancel, so neither limit can be violated.
        if (inc && !dec) begin
            if (cnt_q == CNT_MAX) ovf   = 1'b1;
            else                  cnt_d = cnt_q + CNT_ONE;
        end else if (dec && !inc) begin
            if (cnt_q == '0) unf   = 1'b1;
            else             cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign nonzero = (cnt_q != '0);
    assign one     = (cnt_q == CNT_ONE);

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-side RAW and flag hazard scoreboard between ID and the ID/EX register.
// Latency: hazard/issue are combinational; pending state updates on the next edge.
// Backpressure: hazard stalls IF/ID and bubbles ID/EX; ID holds id_* stable meanwhile.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter bit FORWARD_EN = 1'b0,
    parameter bit WB_BYPASS  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_src1,
    input  logic [REG_IDX_W-1:0] id_src2,
    input  logic                 id_src1_en,
    input  logic                 id_src2_en,
    input  logic                 id_wb_en,
    input  logic [REG_IDX_W-1:0] id_dest,
    input  logic                 id_s,
    input  logic                 id_cond_use,
    input  logic                 flush,
    input  logic                 exe_wb_en,
    input  logic                 exe_mem_r_en,
    input  logic [REG_IDX_W-1:0] exe_dest,
    input  logic                 wb_retire,
    input  logic [REG_IDX_W-1:0] wb_dest,
    input  logic                 sr_update,
    output logic                 hazard,
    output logic                 issue,
    output logic [NUM_REGS-1:0]  busy,
    output logic                 sr_pending,
    output logic                 err
);

    logic [NUM_REGS-1:0] cnt_nz;
    logic [NUM_REGS-1:0] cnt_one;
    logic [NUM_REGS-1:0] cnt_ovf;
    logic [NUM_REGS-1:0] cnt_unf;
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;

    logic src1_hit;
    logic src2_hit;
    logic flag_hit;

    logic sr_pending_q, sr_pending_d;
    logic err_q, err_d;

    always_comb begin
        src1_hit = 1'b0;
        src2_hit = 1'b0;
        if (FORWARD_EN) begin
            // Only a load still in EXE cannot be forwarded in time.
            src1_hit = id_src1_en & exe_mem_r_en & exe_wb_en & (exe_dest == id_src1);
            src2_hit = id_src2_en & exe_mem_r_en & exe_wb_en & (exe_dest == id_src2);
        end else begin
            src1_hit = id_src1_en & cnt_nz[id_src1]
                     & ~(WB_BYPASS & wb_retire & (wb_dest == id_src1) & cnt_one[id_src1]);
            src2_hit = id_src2_en & cnt_nz[id_src2]
                     & ~(WB_BYPASS & wb_retire & (wb_dest == id_src2) & cnt_one[id_src2]);
        end
        flag_hit = id_cond_use & sr_pending_q & ~sr_update;
    end

    assign hazard = id_valid & ~flush & (src1_hit | src2_hit | flag_hit);
    assign issue  = id_valid & ~hazard & ~flush;

    assign inc_vec = (issue && id_wb_en) ? reg_onehot(id_dest) : '0;
    assign dec_vec = wb_retire ? reg_onehot(wb_dest) : '0;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
        sb_counter u_cnt (
            .clk     (clk),
            .rst     (rst),
            .inc     (inc_vec[r]),
            .dec     (dec_vec[r]),
            .nonzero (cnt_nz[r]),
            .one     (cnt_one[r]),
            .ovf     (cnt_ovf[r]),
            .unf     (cnt_unf[r])
        );
    end

    always_comb begin
        sr_pending_d = sr_pending_q;
        // A newly issued S instruction outranks the retiring flag write.
        if (issue && id_s)   sr_pending_d = 1'b1;
        else if (sr_update)  sr_pending_d = 1'b0;
        err_d = err_q | (|cnt_ovf) | (|cnt_unf);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_pending_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            sr_pending_q <= sr_pending_d;
            err_q        <= err_d;
        end
    end

    assign busy       = cnt_nz;
    assign sr_pending = sr_pending_q;
    assign err        = err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed checks of the hazard scoreboard in stall-only and forwarding configurations.
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [3:0]  id_src1, id_src2, id_dest;
    logic        id_src1_en, id_src2_en, id_wb_en, id_s, id_cond_use;
    logic        flush;
    logic        exe_wb_en, exe_mem_r_en;
    logic [3:0]  exe_dest;
    logic        wb_retire;
    logic [3:0]  wb_dest;
    logic        sr_update;

    logic        hazard, issue, sr_pending, err;
    logic [15:0] busy;
    logic        hazard_f, issue_f, sr_pending_f, err_f;
    logic [15:0] busy_f;

    int total = 0;
    int bad   = 0;

    hazard_scoreboard #(.FORWARD_EN(1'b0), .WB_BYPASS(1'b1)) u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_src1_en(id_src1_en), .id_src2_en(id_src2_en),
        .id_wb_en(id_wb_en), .id_dest(id_dest), .id_s(id_s), .id_cond_use(id_cond_use),
        .flush(flush), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .exe_dest(exe_dest),
        .wb_retire(wb_retire), .wb_dest(wb_dest), .sr_update(sr_update),
        .hazard(hazard), .issue(issue), .busy(busy), .sr_pending(sr_pending), .err(err)
    );

    hazard_scoreboard #(.FORWARD_EN(1'b1), .WB_BYPASS(1'b1)) u_dut_fwd (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_src1_en(id_src1_en), .id_src2_en(id_src2_en),
        .id_wb_en(id_wb_en), .id_dest(id_dest), .id_s(id_s), .id_cond_use(id_cond_use),
        .flush(flush), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .exe_dest(exe_dest),
        .wb_retire(wb_retire), .wb_dest(wb_dest), .sr_update(sr_update),
        .hazard(hazard_f), .issue(issue_f), .busy(busy_f), .sr_pending(sr_pending_f), .err(err_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        id_valid = 0; id_src1 = 0; id_src2 = 0; id_src1_en = 0; id_src2_en = 0;
        id_wb_en = 0; id_dest = 0; id_s = 0; id_cond_use = 0; flush = 0;
        exe_wb_en = 0; exe_mem_r_en = 0; exe_dest = 0;
        wb_retire = 0; wb_dest = 0; sr_update = 0;
    endtask

    initial begin
        clear_in();
        rst = 1'b0;
        #1;
        chk("reset_busy", busy, 16'h0000);
        chk("reset_srp", {15'd0, sr_pending}, 16'd0);
        chk("reset_err", {15'd0, err}, 16'd0);
        chk("reset_hazard", {15'd0, hazard}, 16'd0);
        #12 rst = 1'b1;
        tick();

        // Back-to-back RAW on R3, stall-only configuration
        id_valid = 1; id_wb_en = 1; id_dest = 3;
        #1;
        chk("raw_issue_add", {15'd0, issue}, 16'd1);
        chk("raw_add_nohaz", {15'd0, hazard}, 16'd0);
        tick();
        chk("raw_busy3", busy, 16'h0008);
        id_wb_en = 0; id_src1 = 3; id_src1_en = 1;
        #1;
        chk("raw_stall1", {15'd0, hazard}, 16'd1);
        chk("raw_stall1_issue", {15'd0, issue}, 16'd0);
        tick();
        chk("raw_stall2", {15'd0, hazard}, 16'd1);
        tick();
        wb_retire = 1; wb_dest = 3;
        #1;
        chk("raw_bypass_hazard", {15'd0, hazard}, 16'd0);
        chk("raw_bypass_issue", {15'd0, issue}, 16'd1);
        tick();
        chk("raw_busy_clear", busy, 16'h0000);

        // Same-register issue and retire
        clear_in();
        id_valid = 1; id_wb_en = 1; id_dest = 7;
        tick();
        wb_retire = 1; wb_dest = 7;
        #1;
        chk("same_issue", {15'd0, issue}, 16'd1);
        tick();
        chk("same_busy7", busy, 16'h0080);
        chk("same_err", {15'd0, err}, 16'd0);
        clear_in();
        wb_retire = 1; wb_dest = 7;
        tick();
        chk("same_drain", busy, 16'h0000);
        chk("same_drain_err", {15'd0, err}, 16'd0);

        // Flag hazard: SUBS then BNE
        clear_in();
        id_valid = 1; id_s = 1;
        tick();
        chk("flag_srp_set", {15'd0, sr_pending}, 16'd1);
        id_s = 0; id_cond_use = 1;
        #1;
        chk("flag_stall1", {15'd0, hazard}, 16'd1);
        tick();
        chk("flag_stall2", {15'd0, hazard}, 16'd1);
        sr_update = 1;
        #1;
        chk("flag_release", {15'd0, hazard}, 16'd0);
        chk("flag_release_issue", {15'd0, issue}, 16'd1);
        tick();
        chk("flag_srp_clr", {15'd0, sr_pending}, 16'd0);
        clear_in();
        id_valid = 1; id_s = 1;
        tick();
        sr_update = 1;
        tick();
        chk("flag_set_wins", {15'd0, sr_pending}, 16'd1);
        clear_in();
        sr_update = 1;
        tick();
        chk("flag_final_clr", {15'd0, sr_pending}, 16'd0);

        // Load-use vs ALU producer with forwarding
        clear_in();
        exe_wb_en = 1; exe_mem_r_en = 1; exe_dest = 5;
        id_valid = 1; id_src1 = 5; id_src1_en = 1;
        #1;
        chk("fwd_load_use", {15'd0, hazard_f}, 16'd1);
        chk("fwd_load_issue", {15'd0, issue_f}, 16'd0);
        chk("nofwd_r5_free", {15'd0, hazard}, 16'd0);
        tick();
        exe_mem_r_en = 0;
        #1;
        chk("fwd_alu_nostall", {15'd0, hazard_f}, 16'd0);
        chk("fwd_alu_issue", {15'd0, issue_f}, 16'd1);
        tick();

        // Flush suppresses hazard and issue
        clear_in();
        id_valid = 1; id_wb_en = 1; id_dest = 4;
        tick();
        id_src1 = 4; id_src1_en = 1; flush = 1;
        #1;
        chk("flush_hazard", {15'd0, hazard}, 16'd0);
        chk("flush_issue", {15'd0, issue}, 16'd0);
        tick();
        chk("flush_busy4", busy, 16'h0010);
        clear_in();
        wb_retire = 1; wb_dest = 4;
        tick();
        chk("flush_no_inc", busy, 16'h0000);
        chk("flush_err", {15'd0, err}, 16'd0);

        // Underflow error is sticky
        clear_in();
        wb_retire = 1; wb_dest = 9;
        tick();
        chk("unf_err", {15'd0, err}, 16'd1);
        clear_in();
        tick();
        tick();
        chk("unf_sticky", {15'd0, err}, 16'd1);

        // Reset in the middle of a stall
        id_valid = 1; id_wb_en = 1; id_dest = 2; id_s = 1;
        tick();
        id_wb_en = 0; id_s = 0; id_src1 = 2; id_src1_en = 1; id_cond_use = 1;
        #1;
        chk("rst_pre_stall", {15'd0, hazard}, 16'd1);
        chk("rst_pre_busy", busy, 16'h0004);
        rst = 1'b0;
        #1;
        chk("rst_busy", busy, 16'h0000);
        chk("rst_srp", {15'd0, sr_pending}, 16'd0);
        chk("rst_hazard", {15'd0, hazard}, 16'd0);
        chk("rst_err", {15'd0, err}, 16'd0);
        chk("rst_issue", {15'd0, issue}, 16'd1);
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_busy", busy, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
